rsa_stream_ctrl: RTL and testbench

- Byte-stream front end for the 256-bit modular-exponentiation core (`Power`).
- Receives modulus, exponent and base as a byte stream and holds them on the core's operand inputs.
- Launches the core with a falling edge on its `start` and waits for its level `done`.
- Streams the 256-bit result back out as bytes over a valid/ready handshake. Sits between the UART byte layer and `Power`.

---
 rtl/rsa_stream_ctrl.sv | 124 ++++++++++++
 tb/tb_rsa_stream_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_stream_ctrl.sv
// Byte-stream front end for the modular-exponentiation core: loads modulus,
// exponent and base, launches the core, and streams the result back as bytes.
module rsa_stream_ctrl #(
  parameter int NBYTES = 32,
  parameter int GUARD  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  pw_start,
  output logic [8*NBYTES-1:0]   pw_a1,
  output logic [8*NBYTES-1:0]   pw_a2,
  output logic [8*NBYTES-1:0]   pw_a3,
  input  logic                  pw_done,
  input  logic [8*NBYTES-1:0]   pw_a0,
  output logic                  busy,
  output logic                  overrun
);
  localparam int W  = 8 * NBYTES;
  localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;
  localparam logic [BW-1:0] BLAST = BW'(NBYTES - 1);
  localparam logic [GW-1:0] GLAST = GW'((GUARD > 0) ? GUARD - 1 : 0);

  typedef enum logic [2:0] {
    S_LOAD_N, S_LOAD_E, S_LOAD_X, S_LAUNCH, S_WAIT, S_SEND
  } state_t;

  state_t         r_state;
  logic [BW-1:0]  r_bcnt;
  logic [GW-1:0]  r_guard;
  logic [W-1:0]   r_a1, r_a2, r_a3, r_tx;
  logic           r_start, r_txv, r_ovr;

  logic w_last, w_load;
  assign w_last = (r_bcnt == BLAST);
  assign w_load = (r_state == S_LOAD_N) || (r_state == S_LOAD_E) || (r_state == S_LOAD_X);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD_N;
      r_bcnt  <= '0;
      r_guard <= '0;
      r_a1    <= '0;
      r_a2    <= '0;
      r_a3    <= '0;
      r_tx    <= '0;
      r_start <= 1'b1;
      r_txv   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      // Bytes outside the load states are dropped but remembered as overrun.
      if (rx_valid && !w_load) r_ovr <= 1'b1;
      case (r_state)
        S_LOAD_N, S_LOAD_E, S_LOAD_X: begin
          if (rx_valid) begin
            case (r_state)
              S_LOAD_N: r_a3 <= {r_a3[W-9:0], rx_data};
              S_LOAD_E: r_a2 <= {r_a2[W-9:0], rx_data};
              default:  r_a1 <= {r_a1[W-9:0], rx_data};
            endcase
            r_bcnt <= w_last ? '0 : r_bcnt + 1'b1;
            if (w_last) begin
              case (r_state)
                S_LOAD_N: r_state <= S_LOAD_E;
                S_LOAD_E: r_state <= S_LOAD_X;
                default: begin
                  r_state <= S_LAUNCH;
                  r_start <= 1'b0;
                end
              endcase
            end
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT;
          r_guard <= '0;
          r_start <= 1'b1;
        end
        S_WAIT: begin
          // The core's done is still high from the previous run right after launch.
          if (r_guard != GLAST) begin
            r_guard <= r_guard + 1'b1;
          end else if (pw_done) begin
            r_tx    <= pw_a0;
            r_bcnt  <= '0;
            r_txv   <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            r_tx <= r_tx << 8;
            if (w_last) begin
              r_bcnt  <= '0;
              r_txv   <= 1'b0;
              r_state <= S_LOAD_N;
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_LOAD_N;
          r_start <= 1'b1;
          r_txv   <= 1'b0;
        end
      endcase
    end
  end

  assign pw_start = r_start;
  assign tx_valid = r_txv;
  assign tx_data  = r_tx[W-1 -: 8];
  assign pw_a1    = r_a1;
  assign pw_a2    = r_a2;
  assign pw_a3    = r_a3;
  assign overrun  = r_ovr;
  assign busy     = !((r_state == S_LOAD_N) && (r_bcnt == '0));
endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Bench for rsa_stream_ctrl: a stub Power core with 20-cycle latency, table
// frames with known results, corner sequences and randomized frames.
module tb_rsa_stream_ctrl;
  localparam int NB  = 32;
  localparam int W   = 8 * NB;
  localparam int LAT = 20;

  logic         clk, rst_n;
  logic [7:0]   rx_data, tx_data;
  logic         rx_valid, tx_valid, tx_ready;
  logic         pw_start, pw_done, busy, overrun;
  logic [W-1:0] pw_a1, pw_a2, pw_a3, pw_a0;

  rsa_stream_ctrl #(.NBYTES(NB), .GUARD(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .pw_start(pw_start), .pw_a1(pw_a1), .pw_a2(pw_a2), .pw_a3(pw_a3),
    .pw_done(pw_done), .pw_a0(pw_a0), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] m, e, b, res;
    int           rmode;   // 0: ready high, 1: 1,0,0 pattern, 2: random
    int           extra;   // stray bytes sent while waiting on the core
    bit           stale;   // core holds done past the launch
  } vec_t;

  int n_vec = 0, n_err = 0;
  int nfall = 0, lowcnt = 0, last_low = 0;
  bit st_m = 1'b1, have_hold = 1'b0, ovr_exp = 1'b0;
  logic [7:0] hold;
  logic [7:0] rxq[$];

  function automatic logic [W-1:0] mexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                        input logic [W-1:0] m);
    logic [2*W-1:0] r, bb, mm;
    mm = {{W{1'b0}}, m};
    r  = {{(2*W-1){1'b0}}, 1'b1} % mm;
    bb = {{W{1'b0}}, b} % mm;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * bb) % mm;
      bb = (bb * bb) % mm;
    end
    return r[W-1:0];
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Power stub: drops done drop_dly cycles after launch, answers after LAT cycles.
  int st_cnt = 0, drop_dly = 0;
  bit st_run = 1'b0, st_prev = 1'b1;
  logic [W-1:0] la1, la2, la3;
  always @(posedge clk) begin
    #1;
    if (st_prev && !pw_start) begin
      st_run = 1'b1; st_cnt = 0;
      la1 = pw_a1; la2 = pw_a2; la3 = pw_a3;
      if (drop_dly == 0) pw_done = 1'b0;
    end else if (st_run) begin
      st_cnt++;
      if (st_cnt == drop_dly) pw_done = 1'b0;
      if (st_cnt == LAT) begin
        pw_done = 1'b1;
        pw_a0   = mexp(la1, la2, la3);
        st_run  = 1'b0;
      end
    end
    st_prev = pw_start;
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!pw_start) lowcnt++;
    else begin
      if (lowcnt > 0) last_low = lowcnt;
      lowcnt = 0;
    end
    if (st_m && !pw_start) nfall++;
    st_m = pw_start;
    if (tx_valid) begin
      if (have_hold) chk("stall_stable", {{(W-8){1'b0}}, tx_data}, {{(W-8){1'b0}}, hold});
      if (tx_ready) begin
        rxq.push_back(tx_data);
        have_hold = 1'b0;
      end else begin
        have_hold = 1'b1;
        hold = tx_data;
      end
    end else have_hold = 1'b0;
  end

  task automatic send_byte(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input bit rnd_gap);
    int f0;
    bit to;
    logic [W-1:0] op, res;
    f0 = nfall;
    rxq.delete();
    if (v.stale) begin
      pw_done = 1'b1; pw_a0 = {8{32'hDEADBEEF}}; drop_dly = 2;
    end else drop_dly = 0;
    for (int k = 0; k < 3*NB; k++) begin
      op = (k < NB) ? v.m : (k < 2*NB) ? v.e : v.b;
      send_byte(op[(NB-1-(k%NB))*8 +: 8]);
      if (rnd_gap) repeat ($urandom_range(0, 2)) step();
    end
    if (v.extra > 0) begin
      repeat (3) step();
      repeat (v.extra) send_byte(8'hA5);
      ovr_exp = 1'b1;
    end
    to = 1'b1;
    for (int t = 0; t < 4000; t++) begin
      case (v.rmode)
        0: tx_ready = 1'b1;
        1: tx_ready = (t % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      if (rxq.size() >= NB && !busy) begin
        to = 1'b0;
        break;
      end
    end
    tx_ready = 1'b0;
    chk("timeout", W'(to), '0);
    res = '0;
    foreach (rxq[i]) res = {res[W-9:0], rxq[i]};
    chk("result", res, v.res);
    chk("nbytes", W'(rxq.size()), W'(NB));
    chk("start_falls", W'(nfall - f0), W'(1));
    chk("start_low_len", W'(last_low), W'(1));
    chk("a3_hold", pw_a3, v.m);
    chk("a2_hold", pw_a2, v.e);
    chk("a1_hold", pw_a1, v.b);
    chk("overrun", W'(overrun), W'(ovr_exp));
    chk("tx_valid_idle", W'(tx_valid), '0);
  endtask

  vec_t tbl[5];
  vec_t rv;
  int f0;

  initial begin
    tbl[0] = '{W'(497),  W'(13), W'(4), W'(445), 0, 0, 1'b0};
    tbl[1] = '{W'(1000), W'(3),  W'(7), W'(343), 1, 0, 1'b0};
    tbl[2] = '{W'(1000), W'(10), W'(2), W'(24),  0, 0, 1'b1};
    tbl[3] = '{W'(7),    W'(0),  W'(5), W'(1),   1, 3, 1'b0};
    tbl[4] = '{W'(1009), W'(5),  W'(3), W'(243), 2, 0, 1'b0};

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    pw_done = 1'b0; pw_a0 = '0;
    repeat (3) step();
    nfall = 0;
    chk("rst_start", W'(pw_start), W'(1));
    chk("rst_txv", W'(tx_valid), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_ovr", W'(overrun), '0);
    chk("rst_a3", pw_a3, '0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_frame(tbl[i], 1'b0);

    // Reset in the middle of loading: 40 bytes, then an async pulse.
    f0 = nfall;
    for (int k = 0; k < 40; k++) send_byte(8'(k + 1));
    chk("midload_busy", W'(busy), W'(1));
    #2 rst_n = 1'b0;
    #2;
    chk("mid_rst_start", W'(pw_start), W'(1));
    chk("mid_rst_txv", W'(tx_valid), '0);
    chk("mid_rst_busy", W'(busy), '0);
    chk("mid_rst_ovr", W'(overrun), '0);
    chk("mid_rst_a3", pw_a3, '0);
    chk("mid_rst_a2", pw_a2, '0);
    chk("mid_rst_txd", W'(tx_data), '0);
    step();
    rst_n = 1'b1;
    ovr_exp = 1'b0;
    step();
    chk("mid_rst_nofall", W'(nfall - f0), '0);
    run_frame(tbl[0], 1'b0);

    // Randomized frames against the arithmetic model.
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 8; j++) begin
        rv.m[j*32 +: 32] = $urandom;
        rv.e[j*32 +: 32] = $urandom;
        rv.b[j*32 +: 32] = $urandom;
      end
      rv.m[W-1] = 1'b1;
      rv.res = mexp(rv.b, rv.e, rv.m);
      rv.rmode = 2; rv.extra = 0; rv.stale = 1'b0;
      run_frame(rv, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
